bcd_to_7segment: RTL and testbench
==================================

BCD_TO_7SEGMENT -- requirements
Module: bcd_to_7segment

Interface
REQ-001 SHALL have parameter: SEG_ACTIVE_LOW, default 0, 1 inverts all seg bits at output (common-anode panel).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: bcd  input  4  digit code to display.
REQ-005 SHALL have port: in_valid  input  1  bcd qualifier; code captured only when high.
REQ-006 SHALL have port: blank  input  1  force all segments off.
REQ-007 SHALL have port: lamp_test  input  1  force all segments on.
REQ-008 SHALL have port: seg  output  7  segment drive, bit order {g,f,e,d,c,b,a}, seg[0]=a.
REQ-009 SHALL have port: out_valid  output  1  seg updated from a captured code this cycle.
REQ-010 SHALL have port: err  output  1  captured code was not a displayable digit.

Function
REQ-011 SHALL register seg, out_valid, err; latency exactly 1 clk from in_valid sample to output.
REQ-012 SHALL decode, active-high pattern: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
REQ-013 SHALL, for codes 10-15 without HEX_DIGITS_EN, output blank pattern 0x00 and assert err for that cycle's result.
REQ-014 SHALL hold seg and err at last values when in_valid=0; out_valid=0 that cycle.
REQ-015 SHALL set out_valid = registered in_valid (1-cycle pulse per accepted code, no backpressure).
REQ-016 SHALL apply priority lamp_test > blank > decode; lamp_test gives 0x7F, blank gives 0x00, both independent of in_valid and effective on next edge.
REQ-017 SHALL clear err while lamp_test or blank forces output; err reflects only decoded codes.
REQ-018 SHALL apply SEG_ACTIVE_LOW inversion last, after priority selection, including blank and reset values.

Reset
REQ-019 SHALL on rst=1 at rising edge set seg to blank pattern (0x00, or 0x7F if SEG_ACTIVE_LOW=1), out_valid=0, err=0.
REQ-020 SHALL give rst priority over lamp_test, blank, in_valid; code presented during reset cycle is discarded.
REQ-021 SHALL accept new codes on the first edge after rst deasserts.

Configuration
REQ-022 SHALL support macro BCD7SEG_HEX_DIGITS_EN; when defined, codes 10-15 decode to A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71 with err=0.
REQ-023 SHALL, without BCD7SEG_HEX_DIGITS_EN, behave per REQ-013; err port present in both builds.

Structure
REQ-024 SHALL place the 16 segment pattern constants, SEG_BLANK, SEG_ALL, and a 7-bit seg_t typedef in package bcd7seg_pkg.
REQ-025 SHALL implement the pure combinational code-to-pattern table in sub-module seg_decode (inputs code[3:0]; outputs pattern[6:0], invalid); top owns registers, priority, polarity.

Verification
REQ-026 SHALL cover: reset then in_valid=1 bcd=0..9 each cycle -> seg 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F, one cycle later, out_valid=1, err=0.
REQ-027 SHALL cover: bcd=12 in_valid=1 -> seg=0x00 err=1 (no macro); seg=0x39 err=0 (BCD7SEG_HEX_DIGITS_EN).
REQ-028 SHALL cover: bcd=8 accepted, then in_valid=0 for 3 cycles with bcd=3 -> seg holds 0x7F, out_valid=0.
REQ-029 SHALL cover: lamp_test=1 and blank=1 with bcd=2 -> seg=0x7F; lamp_test drops -> seg=0x00; both low with bcd=2 valid -> 0x5B.
REQ-030 SHALL cover: SEG_ACTIVE_LOW=1, bcd=0 -> seg=0x40; rst mid-stream -> seg=0x7F, out_valid=0, err=0 next edge.

Source files
------------

// File: rtl/bcd7seg_pkg.sv
// Shared types and constants for the BCD to seven-segment display driver.
// Segment vectors are {g,f,e,d,c,b,a} with bit 0 = segment a, active-high.
package bcd7seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_ALL   = 7'h7F;

    localparam seg_t SEG_0 = 7'h3F;
    localparam seg_t SEG_1 = 7'h06;
    localparam seg_t SEG_2 = 7'h5B;
    localparam seg_t SEG_3 = 7'h4F;
    localparam seg_t SEG_4 = 7'h66;
    localparam seg_t SEG_5 = 7'h6D;
    localparam seg_t SEG_6 = 7'h7D;
    localparam seg_t SEG_7 = 7'h07;
    localparam seg_t SEG_8 = 7'h7F;
    localparam seg_t SEG_9 = 7'h6F;
    localparam seg_t SEG_A = 7'h77;
    localparam seg_t SEG_B = 7'h7C;
    localparam seg_t SEG_C = 7'h39;
    localparam seg_t SEG_D = 7'h5E;
    localparam seg_t SEG_E = 7'h79;
    localparam seg_t SEG_F = 7'h71;

    // Convert an active-high pattern to the panel's drive polarity.
    function automatic seg_t apply_polarity(input seg_t s, input bit active_low);
        return active_low ? ~s : s;
    endfunction

endpackage

// File: rtl/bcd_to_7segment_seg_decode.sv
// Pure combinational digit-code to segment-pattern table.
// Build option: BCD7SEG_HEX_DIGITS_EN makes codes 10-15 display A,b,C,d,E,F;
// without it those codes produce a blank pattern and raise invalid.
module seg_decode
    import bcd7seg_pkg::*;
(
    input  logic [3:0] code,
    output seg_t       pattern,
    output logic       invalid
);

    // Look up the active-high pattern for the code.
    always_comb begin
        pattern = SEG_BLANK;
        invalid = 1'b0;
        case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: begin
`ifdef BCD7SEG_HEX_DIGITS_EN
                case (code)
                    4'd10:   pattern = SEG_A;
                    4'd11:   pattern = SEG_B;
                    4'd12:   pattern = SEG_C;
                    4'd13:   pattern = SEG_D;
                    4'd14:   pattern = SEG_E;
                    default: pattern = SEG_F;
                endcase
`else
                pattern = SEG_BLANK;
                invalid = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/bcd_to_7segment.sv
// Registered BCD to seven-segment driver with lamp test, blanking and
// selectable panel polarity (SEG_ACTIVE_LOW=1 for common-anode panels).
// Build option: BCD7SEG_HEX_DIGITS_EN (see seg_decode) enables hex digits.
//
// Handshake: in_valid qualifies bcd on each rising edge; there is no ready,
// every valid code is accepted. out_valid is in_valid delayed one clock and
// marks the cycle whose seg/err came from that accepted code. With in_valid
// low, seg and err hold. lamp_test (all on) beats blank (all off) beats the
// decoded digit; forced outputs clear err. rst beats everything.
module bcd_to_7segment
    import bcd7seg_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd,
    input  logic       in_valid,
    input  logic       blank,
    input  logic       lamp_test,
    output logic [6:0] seg,
    output logic       out_valid,
    output logic       err
);

    seg_t dec_pattern;
    logic dec_invalid;

    seg_decode u_decode (
        .code    (bcd),
        .pattern (dec_pattern),
        .invalid (dec_invalid)
    );

    // Output register: reset, then priority select, polarity applied last.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg       <= apply_polarity(SEG_BLANK, SEG_ACTIVE_LOW);
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (lamp_test) begin
                seg <= apply_polarity(SEG_ALL, SEG_ACTIVE_LOW);
                err <= 1'b0;
            end else if (blank) begin
                seg <= apply_polarity(SEG_BLANK, SEG_ACTIVE_LOW);
                err <= 1'b0;
            end else if (in_valid) begin
                seg <= apply_polarity(dec_pattern, SEG_ACTIVE_LOW);
                err <= dec_invalid;
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_7segment.sv
// Bench for bcd_to_7segment: an active-high and an active-low instance share
// the same stimulus. Directed vectors come from a table, then random traffic
// is checked against a small reference model.
module tb_bcd_to_7segment;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bcd = 4'd0;
    logic       in_valid = 1'b0;
    logic       blank = 1'b0;
    logic       lamp_test = 1'b0;
    logic [6:0] seg_hi, seg_lo;
    logic       ov_hi, ov_lo, err_hi, err_lo;

    int pass_cnt = 0;
    int total_cnt = 0;

`ifdef BCD7SEG_HEX_DIGITS_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    bcd_to_7segment #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .bcd(bcd), .in_valid(in_valid), .blank(blank),
        .lamp_test(lamp_test), .seg(seg_hi), .out_valid(ov_hi), .err(err_hi)
    );

    bcd_to_7segment #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .bcd(bcd), .in_valid(in_valid), .blank(blank),
        .lamp_test(lamp_test), .seg(seg_lo), .out_valid(ov_lo), .err(err_lo)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] bcd;
        logic       blank;
        logic       lamp;
        logic [6:0] seg;
        logic       ov;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    logic [8:0] exp_q[$];   // {seg(active-high), out_valid, err}
    logic [6:0] ref_pat[16];

    function automatic vec_t mk(input logic r, input logic iv, input logic [3:0] b,
                                input logic bl, input logic lt, input logic [6:0] s,
                                input logic ov, input logic e);
        vec_t v;
        v.rst = r; v.iv = iv; v.bcd = b; v.blank = bl; v.lamp = lt;
        v.seg = s; v.ov = ov; v.err = e;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [6:0] act,
                         input logic [6:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s #%0d: act=0x%02h req=0x%02h", name, idx, act, req);
    endtask

    // driver: apply one input set on the falling edge and queue its result
    task automatic drive(input logic r, input logic iv, input logic [3:0] b,
                         input logic bl, input logic lt, input logic [8:0] exp);
        @(negedge clk);
        rst = r; in_valid = iv; bcd = b; blank = bl; lamp_test = lt;
        exp_q.push_back(exp);
    endtask

    // scoreboard: after the next rising edge, compare both instances
    task automatic sample(input int idx);
        logic [8:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL queue_empty #%0d: act=0 req=1", idx);
            return;
        end
        e = exp_q.pop_front();
        check("seg_hi", idx, seg_hi, e[8:2]);
        check("seg_lo", idx, seg_lo, ~e[8:2]);
        check("ov_hi",  idx, {6'd0, ov_hi},  {6'd0, e[1]});
        check("ov_lo",  idx, {6'd0, ov_lo},  {6'd0, e[1]});
        check("err_hi", idx, {6'd0, err_hi}, {6'd0, e[0]});
        check("err_lo", idx, {6'd0, err_lo}, {6'd0, e[0]});
    endtask

    logic [6:0] m_seg;
    logic       m_err;

    initial begin
        logic [6:0] p12, p15;
        logic       e_hex;
        logic       r, iv, bl, lt;
        logic [3:0] b;
        logic       m_ov;

        ref_pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        p12   = HEX ? 7'h39 : 7'h00;
        p15   = HEX ? 7'h71 : 7'h00;
        e_hex = ~HEX;

        // table:      rst iv  bcd  bl  lt   seg    ov err
        vecs.push_back(mk(1, 0, 4'd0, 0, 0, 7'h00, 0, 0));
        for (int d = 0; d < 10; d++)
            vecs.push_back(mk(0, 1, 4'(d), 0, 0, ref_pat[d], 1, 0));
        vecs.push_back(mk(0, 1, 4'd12, 0, 0, p12,   1, e_hex));
        vecs.push_back(mk(0, 1, 4'd8,  0, 0, 7'h7F, 1, 0));
        vecs.push_back(mk(0, 0, 4'd3,  0, 0, 7'h7F, 0, 0));
        vecs.push_back(mk(0, 0, 4'd3,  0, 0, 7'h7F, 0, 0));
        vecs.push_back(mk(0, 0, 4'd3,  0, 0, 7'h7F, 0, 0));
        vecs.push_back(mk(0, 1, 4'd12, 0, 0, p12,   1, e_hex));
        vecs.push_back(mk(0, 0, 4'd3,  0, 0, p12,   0, e_hex));
        vecs.push_back(mk(0, 1, 4'd2,  1, 1, 7'h7F, 1, 0));
        vecs.push_back(mk(0, 1, 4'd2,  1, 0, 7'h00, 1, 0));
        vecs.push_back(mk(0, 1, 4'd2,  0, 0, 7'h5B, 1, 0));
        vecs.push_back(mk(0, 0, 4'd4,  0, 1, 7'h7F, 0, 0));
        vecs.push_back(mk(0, 1, 4'd0,  0, 0, 7'h3F, 1, 0));
        vecs.push_back(mk(1, 1, 4'd5,  0, 1, 7'h00, 0, 0));
        vecs.push_back(mk(0, 1, 4'd7,  0, 0, 7'h07, 1, 0));
        vecs.push_back(mk(0, 1, 4'd15, 0, 0, p15,   1, e_hex));
        vecs.push_back(mk(1, 0, 4'd1,  0, 0, 7'h00, 0, 0));

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].bcd, vecs[i].blank, vecs[i].lamp,
                  {vecs[i].seg, vecs[i].ov, vecs[i].err});
            sample(i);
        end

        // random traffic against the reference model (state follows last vector)
        m_seg = 7'h00;
        m_err = 1'b0;
        for (int k = 0; k < 80; k++) begin
            r  = ($urandom_range(0, 15) == 0);
            lt = ($urandom_range(0, 7) == 0);
            bl = ($urandom_range(0, 7) == 0);
            iv = ($urandom_range(0, 3) != 0);
            b  = 4'($urandom_range(0, 15));
            if (r) begin
                m_seg = 7'h00; m_err = 1'b0; m_ov = 1'b0;
            end else begin
                m_ov = iv;
                if (lt) begin
                    m_seg = 7'h7F; m_err = 1'b0;
                end else if (bl) begin
                    m_seg = 7'h00; m_err = 1'b0;
                end else if (iv) begin
                    if (b > 4'd9 && !HEX) begin
                        m_seg = 7'h00; m_err = 1'b1;
                    end else begin
                        m_seg = ref_pat[b]; m_err = 1'b0;
                    end
                end
            end
            drive(r, iv, b, bl, lt, {m_seg, m_ov, m_err});
            sample(1000 + k);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
